// File: rtl/decode_stage_pipe.sv
// ---------------------------------------------------------------------------
// decode_stage_pipe
//   Decode stage of the pipelined MIPS core. This block does the following:
//   - Splits the instruction into its fields.
//   - Reads the register file.
//   - Forwards operands from EX/MEM/WB.
//   - Stalls on a load-use hazard.
//   - Resolves branches and jumps.
//   - Holds the results in a registered ID/EX boundary with a valid/ready
//     handshake.
//
// Ports
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_valid / o_ready       IF/ID handshake (o_ready = decode accepts)
//   i_pc, i_instr           PC+4 and instruction word
//   i_flush                 kill ID/EX contents (exception/eret)
//   i_ex_ready              execute stage accepts ID/EX this cycle
//   i_ex_*                  EX forward source (+ load flag for hazard)
//   i_mem_*                 MEM forward source
//   i_wb_*                  regfile write port, also a forward source
//   o_valid, o_op1, o_op2,
//   o_imm, o_wr_addr,
//   o_opcode, o_func        registered ID/EX contents
//   o_nextpc, o_redirect    combinational fetch redirect
// ---------------------------------------------------------------------------
module decode_stage_pipe #(
    parameter int DATA_W = 32,
    parameter int REGS   = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_pc,
    input  logic [31:0]       i_instr,
    input  logic              i_flush,
    input  logic              i_ex_ready,
    input  logic              i_ex_we,
    input  logic              i_ex_is_load,
    input  logic [4:0]        i_ex_addr,
    input  logic [DATA_W-1:0] i_ex_data,
    input  logic              i_mem_we,
    input  logic [4:0]        i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic              i_wb_we,
    input  logic [4:0]        i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_op1,
    output logic [DATA_W-1:0] o_op2,
    output logic [DATA_W-1:0] o_imm,
    output logic [4:0]        o_wr_addr,
    output logic [5:0]        o_opcode,
    output logic [5:0]        o_func,
    output logic [DATA_W-1:0] o_nextpc,
    output logic              o_redirect
);

    localparam int AW = (REGS > 1) ? $clog2(REGS) : 1;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    // ---------------- field extraction ----------------
    logic [5:0] opcode, func;
    logic [4:0] rs, rt, rd;
    assign opcode = i_instr[31:26];
    assign rs     = i_instr[25:21];
    assign rt     = i_instr[20:16];
    assign rd     = i_instr[15:11];
    assign func   = i_instr[5:0];

    // The shamt field is not used by this stage.
    logic unused_shamt;
    assign unused_shamt = ^i_instr[10:6];

    // Addresses at or above REGS have no storage behind them.
    function automatic logic in_range(input logic [4:0] a);
        return {1'b0, a} < 6'(REGS);
    endfunction

    // ---------------- register file (not reset) ----------------
    logic [DATA_W-1:0] rf_q [REGS];

    always_ff @(posedge i_clk) begin
        if (i_wb_we && i_wb_addr != 5'd0 && in_range(i_wb_addr))
            rf_q[i_wb_addr[AW-1:0]] <= i_wb_data;
    end

    logic [DATA_W-1:0] rf_rs, rf_rt;
    always_comb begin
        rf_rs = '0;
        rf_rt = '0;
        if (in_range(rs)) rf_rs = rf_q[rs[AW-1:0]];
        if (in_range(rt)) rf_rt = rf_q[rt[AW-1:0]];
    end

    // ---------------- operand forwarding ----------------
    // A load in EX has no data yet, so it is never a forward source. That
    // case is covered by the load-use stall instead. WB forwarding also
    // gives the same-cycle write-through of the regfile.
    function automatic logic [DATA_W-1:0] fwd(
        input logic [4:0]        a,
        input logic [DATA_W-1:0] rfv,
        input logic              ex_hit,
        input logic [DATA_W-1:0] ex_d,
        input logic              mem_hit,
        input logic [DATA_W-1:0] mem_d,
        input logic              wb_hit,
        input logic [DATA_W-1:0] wb_d
    );
        if (a == 5'd0)    return '0;
        else if (ex_hit)  return ex_d;
        else if (mem_hit) return mem_d;
        else if (wb_hit)  return wb_d;
        else              return rfv;
    endfunction

    logic              ex_fwd;
    logic [DATA_W-1:0] op1_d, op2_d;
    assign ex_fwd = i_ex_we && !i_ex_is_load;

    always_comb begin
        op1_d = fwd(rs, rf_rs,
                    ex_fwd && i_ex_addr == rs, i_ex_data,
                    i_mem_we && i_mem_addr == rs, i_mem_data,
                    i_wb_we && i_wb_addr == rs, i_wb_data);
        op2_d = fwd(rt, rf_rt,
                    ex_fwd && i_ex_addr == rt, i_ex_data,
                    i_mem_we && i_mem_addr == rt, i_mem_data,
                    i_wb_we && i_wb_addr == rt, i_wb_data);
    end

    // ---------------- hazard / handshake ----------------
    logic uses_rt, stall;
    assign uses_rt = (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
                     (opcode == OP_BNE)   || (opcode == OP_SW);
    assign stall   = i_valid && i_ex_we && i_ex_is_load && i_ex_addr != 5'd0 &&
                     (i_ex_addr == rs || (uses_rt && i_ex_addr == rt));
    assign o_ready = i_ex_ready && !stall && !i_flush;

    // ---------------- branch / jump resolution ----------------
    logic [DATA_W-1:0] imm_d, br_target, j_target, target;
    logic              taken;

    assign imm_d     = {{(DATA_W-16){i_instr[15]}}, i_instr[15:0]};
    assign br_target = i_pc + {imm_d[DATA_W-3:0], 2'b00};
    assign j_target  = {i_pc[DATA_W-1:28], i_instr[25:0], 2'b00};

    always_comb begin
        taken  = 1'b0;
        target = i_pc;
        unique case (opcode)
            OP_BEQ: begin taken = (op1_d == op2_d); target = br_target; end
            OP_BNE: begin taken = (op1_d != op2_d); target = br_target; end
            OP_J:   begin taken = 1'b1;             target = j_target;  end
            OP_RTYPE: if (func == FN_JR) begin
                taken  = 1'b1;
                target = op1_d;
            end
            default: ;
        endcase
    end

    assign o_redirect = i_valid && o_ready && taken;
    assign o_nextpc   = taken ? target : i_pc;

    // ---------------- ID/EX register ----------------
    logic [4:0] wr_addr_d;
    assign wr_addr_d = (opcode == OP_RTYPE) ? rd : rt;

    logic              valid_q;
    logic [DATA_W-1:0] op1_q, op2_q, imm_q;
    logic [4:0]        wr_addr_q;
    logic [5:0]        opcode_q, func_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_q   <= 1'b0;
            op1_q     <= '0;
            op2_q     <= '0;
            imm_q     <= '0;
            wr_addr_q <= '0;
            opcode_q  <= '0;
            func_q    <= '0;
        end else if (i_flush) begin
            // Kill only; the data fields are don't-care once invalid.
            valid_q <= 1'b0;
        end else if (!i_ex_ready) begin
            // Execute is back-pressuring: hold everything.
        end else if (stall || !i_valid) begin
            valid_q <= 1'b0;
        end else begin
            valid_q   <= 1'b1;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            imm_q     <= imm_d;
            wr_addr_q <= wr_addr_d;
            opcode_q  <= opcode;
            func_q    <= func;
        end
    end

    assign o_valid   = valid_q;
    assign o_op1     = op1_q;
    assign o_op2     = op2_q;
    assign o_imm     = imm_q;
    assign o_wr_addr = wr_addr_q;
    assign o_opcode  = opcode_q;
    assign o_func    = func_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
module tb_decode_stage_pipe;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_pc;
    logic [31:0] i_instr;
    logic        i_flush;
    logic        i_ex_ready;
    logic        i_ex_we, i_ex_is_load;
    logic [4:0]  i_ex_addr;
    logic [31:0] i_ex_data;
    logic        i_mem_we;
    logic [4:0]  i_mem_addr;
    logic [31:0] i_mem_data;
    logic        i_wb_we;
    logic [4:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic        o_valid;
    logic [31:0] o_op1, o_op2, o_imm;
    logic [4:0]  o_wr_addr;
    logic [5:0]  o_opcode, o_func;
    logic [31:0] o_nextpc;
    logic        o_redirect;

    int checks   = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    decode_stage_pipe #(.DATA_W(32), .REGS(32)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_pc(i_pc), .i_instr(i_instr), .i_flush(i_flush), .i_ex_ready(i_ex_ready),
        .i_ex_we(i_ex_we), .i_ex_is_load(i_ex_is_load), .i_ex_addr(i_ex_addr),
        .i_ex_data(i_ex_data), .i_mem_we(i_mem_we), .i_mem_addr(i_mem_addr),
        .i_mem_data(i_mem_data), .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr),
        .i_wb_data(i_wb_data), .o_valid(o_valid), .o_op1(o_op1), .o_op2(o_op2),
        .o_imm(o_imm), .o_wr_addr(o_wr_addr), .o_opcode(o_opcode), .o_func(o_func),
        .o_nextpc(o_nextpc), .o_redirect(o_redirect)
    );

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic idle();
        i_valid = 0; i_flush = 0; i_ex_ready = 1; i_pc = 32'h0; i_instr = 32'h0;
        i_ex_we = 0; i_ex_is_load = 0; i_ex_addr = 0; i_ex_data = 0;
        i_mem_we = 0; i_mem_addr = 0; i_mem_data = 0;
        i_wb_we = 0; i_wb_addr = 0; i_wb_data = 0;
    endtask

    task automatic tick();
        @(posedge i_clk); #1;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge i_clk); idle(); i_wb_we = 1; i_wb_addr = a; i_wb_data = d;
        tick(); i_wb_we = 0;
    endtask

    task automatic test_reset();
        i_rst_n = 0; idle();
        repeat (2) tick();
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
        checks++; if (o_op1 !== 32'h0) begin failures++; $display("FAIL reset_op1 got=%h exp=0", o_op1); end
        checks++; if (o_wr_addr !== 5'h0) begin failures++; $display("FAIL reset_wr_addr got=%h exp=0", o_wr_addr); end
        @(negedge i_clk); i_rst_n = 1;
    endtask

    task automatic test_regfile();
        // add r9, r5, r0 with a same-cycle WB write of r5
        @(negedge i_clk); idle(); i_valid = 1; i_pc = 32'h10;
        i_instr = rtype(5'd5, 5'd0, 5'd9, 6'h20);
        i_wb_we = 1; i_wb_addr = 5'd5; i_wb_data = 32'h1234;
        tick();
        checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL wt_valid got=%b exp=1", o_valid); end
        checks++; if (o_op1 !== 32'h1234) begin failures++; $display("FAIL wt_op1 got=%h exp=1234", o_op1); end
        checks++; if (o_op2 !== 32'h0) begin failures++; $display("FAIL wt_op2_r0 got=%h exp=0", o_op2); end
        checks++; if (o_wr_addr !== 5'd9) begin failures++; $display("FAIL wt_wr_addr got=%0d exp=9", o_wr_addr); end
        checks++; if (o_func !== 6'h20) begin failures++; $display("FAIL wt_func got=%h exp=20", o_func); end
        @(negedge i_clk); i_wb_we = 0;
        tick();
        checks++; if (o_op1 !== 32'h1234) begin failures++; $display("FAIL rf_read_r5 got=%h exp=1234", o_op1); end
        // write to r0 is ignored
        @(negedge i_clk); i_instr = rtype(5'd0, 5'd0, 5'd9, 6'h20);
        i_wb_we = 1; i_wb_addr = 5'd0; i_wb_data = 32'hDEAD;
        tick();
        @(negedge i_clk); i_wb_we = 0;
        tick();
        checks++; if (o_op1 !== 32'h0) begin failures++; $display("FAIL r0_read got=%h exp=0", o_op1); end
        wb_write(5'd1, 32'h10);
        wb_write(5'd2, 32'h10);
        wb_write(5'd31, 32'h4000);
    endtask

    task automatic test_forward();
        @(negedge i_clk); idle(); i_valid = 1; i_instr = rtype(5'd3, 5'd3, 5'd4, 6'h20);
        i_ex_we = 1;  i_ex_addr = 5'd3;  i_ex_data = 32'hAA;
        i_mem_we = 1; i_mem_addr = 5'd3; i_mem_data = 32'hBB;
        i_wb_we = 1;  i_wb_addr = 5'd3;  i_wb_data = 32'hCC;
        tick();
        checks++; if (o_op1 !== 32'hAA) begin failures++; $display("FAIL fwd_ex_op1 got=%h exp=aa", o_op1); end
        checks++; if (o_op2 !== 32'hAA) begin failures++; $display("FAIL fwd_ex_op2 got=%h exp=aa", o_op2); end
        @(negedge i_clk); i_ex_we = 0;
        tick();
        checks++; if (o_op1 !== 32'hBB) begin failures++; $display("FAIL fwd_mem_op1 got=%h exp=bb", o_op1); end
        @(negedge i_clk); i_mem_we = 0;
        tick();
        checks++; if (o_op2 !== 32'hCC) begin failures++; $display("FAIL fwd_wb_op2 got=%h exp=cc", o_op2); end
        @(negedge i_clk); i_wb_we = 0;
        tick();
        checks++; if (o_op1 !== 32'hCC) begin failures++; $display("FAIL fwd_rf_op1 got=%h exp=cc", o_op1); end
    endtask

    task automatic test_load_use();
        // lw r7 in EX, decode add r8, r7, r1
        @(negedge i_clk); idle(); i_valid = 1; i_instr = rtype(5'd7, 5'd1, 5'd8, 6'h20);
        i_ex_we = 1; i_ex_is_load = 1; i_ex_addr = 5'd7; i_ex_data = 32'hBAD;
        #1;
        checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL lu_ready got=%b exp=0", o_ready); end
        tick();
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL lu_bubble got=%b exp=0", o_valid); end
        @(negedge i_clk); i_ex_we = 0; i_ex_is_load = 0;
        i_mem_we = 1; i_mem_addr = 5'd7; i_mem_data = 32'h77;
        #1;
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL lu_ready_after got=%b exp=1", o_ready); end
        tick();
        checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL lu_valid_after got=%b exp=1", o_valid); end
        checks++; if (o_op1 !== 32'h77) begin failures++; $display("FAIL lu_mem_op1 got=%h exp=77", o_op1); end
        checks++; if (o_op2 !== 32'h10) begin failures++; $display("FAIL lu_op2 got=%h exp=10", o_op2); end
        checks++; if (o_wr_addr !== 5'd8) begin failures++; $display("FAIL lu_wr_addr got=%0d exp=8", o_wr_addr); end
        // addi r7, r1, 5: rt is a destination, no stall
        @(negedge i_clk); idle(); i_valid = 1; i_instr = itype(6'h08, 5'd1, 5'd7, 16'h0005);
        i_ex_we = 1; i_ex_is_load = 1; i_ex_addr = 5'd7;
        #1;
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL lu_addi_ready got=%b exp=1", o_ready); end
        tick();
        checks++; if (o_wr_addr !== 5'd7) begin failures++; $display("FAIL itype_wr_addr got=%0d exp=7", o_wr_addr); end
        checks++; if (o_imm !== 32'h5) begin failures++; $display("FAIL itype_imm got=%h exp=5", o_imm); end
        // add r8, r1, r7: rt use stalls
        @(negedge i_clk); i_instr = rtype(5'd1, 5'd7, 5'd8, 6'h20);
        #1;
        checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL lu_rt_ready got=%b exp=0", o_ready); end
        // load to r0 never stalls
        i_ex_addr = 5'd0; i_instr = rtype(5'd0, 5'd1, 5'd8, 6'h20);
        #1;
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL lu_r0_ready got=%b exp=1", o_ready); end
    endtask

    task automatic test_branch();
        @(negedge i_clk); idle(); i_valid = 1; i_pc = 32'h100;
        i_instr = itype(6'h04, 5'd1, 5'd2, 16'hFFFE);
        #1;
        checks++; if (o_redirect !== 1'b1) begin failures++; $display("FAIL beq_redirect got=%b exp=1", o_redirect); end
        checks++; if (o_nextpc !== 32'hF8) begin failures++; $display("FAIL beq_nextpc got=%h exp=f8", o_nextpc); end
        i_instr = itype(6'h05, 5'd1, 5'd2, 16'hFFFE);
        #1;
        checks++; if (o_redirect !== 1'b0) begin failures++; $display("FAIL bne_redirect got=%b exp=0", o_redirect); end
        checks++; if (o_nextpc !== 32'h100) begin failures++; $display("FAIL bne_nextpc got=%h exp=100", o_nextpc); end
        i_pc = 32'h1000_0004; i_instr = {6'h02, 26'h000_0040};
        #1;
        checks++; if (o_redirect !== 1'b1) begin failures++; $display("FAIL j_redirect got=%b exp=1", o_redirect); end
        checks++; if (o_nextpc !== 32'h1000_0100) begin failures++; $display("FAIL j_nextpc got=%h exp=10000100", o_nextpc); end
        tick();
        checks++; if (o_opcode !== 6'h02) begin failures++; $display("FAIL j_opcode got=%h exp=02", o_opcode); end
    endtask

    task automatic test_jr();
        @(negedge i_clk); idle(); i_valid = 1; i_pc = 32'h200;
        i_instr = rtype(5'd31, 5'd0, 5'd0, 6'h08);
        #1;
        checks++; if (o_redirect !== 1'b1) begin failures++; $display("FAIL jr_redirect got=%b exp=1", o_redirect); end
        checks++; if (o_nextpc !== 32'h4000) begin failures++; $display("FAIL jr_nextpc got=%h exp=4000", o_nextpc); end
        tick();
        checks++; if (o_op1 !== 32'h4000) begin failures++; $display("FAIL jr_op1 got=%h exp=4000", o_op1); end
        @(negedge i_clk); i_ex_ready = 0;
        #1;
        checks++; if (o_redirect !== 1'b0) begin failures++; $display("FAIL jr_bp_redirect got=%b exp=0", o_redirect); end
        checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL jr_bp_ready got=%b exp=0", o_ready); end
        i_instr = rtype(5'd1, 5'd2, 5'd9, 6'h20);
        tick();
        checks++; if (o_func !== 6'h08) begin failures++; $display("FAIL hold_func got=%h exp=08", o_func); end
        checks++; if (o_op1 !== 32'h4000) begin failures++; $display("FAIL hold_op1 got=%h exp=4000", o_op1); end
        checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL hold_valid got=%b exp=1", o_valid); end
    endtask

    task automatic test_flush();
        @(negedge i_clk); idle(); i_valid = 1; i_instr = rtype(5'd1, 5'd2, 5'd10, 6'h22);
        i_flush = 1;
        #1;
        checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", o_ready); end
        tick();
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", o_valid); end
        checks++; if (o_func !== 6'h08) begin failures++; $display("FAIL flush_hold_func got=%h exp=08", o_func); end
        // flush together with a stalled, taken beq: no redirect
        @(negedge i_clk); i_pc = 32'h100; i_instr = itype(6'h04, 5'd1, 5'd2, 16'hFFFE);
        i_ex_we = 1; i_ex_is_load = 1; i_ex_addr = 5'd1;
        #1;
        checks++; if (o_redirect !== 1'b0) begin failures++; $display("FAIL flush_stall_redirect got=%b exp=0", o_redirect); end
        tick();
    endtask

    task automatic test_back_to_back();
        @(negedge i_clk); idle(); i_valid = 1; i_instr = rtype(5'd1, 5'd2, 5'd11, 6'h20);
        tick();
        checks++; if (o_wr_addr !== 5'd11 || o_valid !== 1'b1) begin failures++; $display("FAIL b2b_first wr=%0d v=%b exp wr=11 v=1", o_wr_addr, o_valid); end
        @(negedge i_clk); i_instr = rtype(5'd31, 5'd1, 5'd12, 6'h22);
        tick();
        checks++; if (o_wr_addr !== 5'd12 || o_func !== 6'h22) begin failures++; $display("FAIL b2b_second wr=%0d fn=%h exp wr=12 fn=22", o_wr_addr, o_func); end
        checks++; if (o_op1 !== 32'h4000) begin failures++; $display("FAIL b2b_op1 got=%h exp=4000", o_op1); end
    endtask

    task automatic test_reset_mid();
        // reset while a load-use stall is pending and ID/EX is valid
        @(negedge i_clk); idle(); i_rst_n = 0; i_valid = 1; i_instr = rtype(5'd7, 5'd1, 5'd8, 6'h20);
        i_ex_we = 1; i_ex_is_load = 1; i_ex_addr = 5'd7;
        tick();
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b exp=0", o_valid); end
        checks++; if (o_op1 !== 32'h0) begin failures++; $display("FAIL rst_mid_op1 got=%h exp=0", o_op1); end
        checks++; if (o_imm !== 32'h0) begin failures++; $display("FAIL rst_mid_imm got=%h exp=0", o_imm); end
        checks++; if (o_func !== 6'h0) begin failures++; $display("FAIL rst_mid_func got=%h exp=0", o_func); end
        @(negedge i_clk); idle(); i_rst_n = 1; i_valid = 1; i_instr = rtype(5'd1, 5'd31, 5'd13, 6'h20);
        tick();
        checks++; if (o_op1 !== 32'h10) begin failures++; $display("FAIL rf_survive_r1 got=%h exp=10", o_op1); end
        checks++; if (o_op2 !== 32'h4000) begin failures++; $display("FAIL rf_survive_r31 got=%h exp=4000", o_op2); end
    endtask

    initial begin
        test_reset();
        test_regfile();
        test_forward();
        test_load_use();
        test_branch();
        test_jr();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
Parametrised successor to the single-cycle decode stage for the pipelined MIPS core. It extracts instruction fields and reads a parametrised register file. It forwards operands from EX/MEM/WB, detects load-use hazards, and resolves branches and jumps in decode. Results are held in a registered ID/EX boundary with valid/ready handshake and flush, so the block sits between the IF/ID register and the execute stage.

Parameters:
DATA_W, 32, datapath width; legal values 32 or 64.
REGS, 32, number of architectural registers; power of two, 2..32.

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst_n  in  1  synchronous active-low reset
i_valid  in  1  IF/ID holds a valid instruction
o_ready  out  1  decode accepts the instruction this cycle
i_pc  in  DATA_W  PC+4 of the instruction
i_instr  in  32  instruction word
i_flush  in  1  exception/eret kill of the ID/EX contents
i_ex_ready  in  1  execute stage accepts ID/EX this cycle
i_ex_we, i_ex_is_load  in  1,1  EX-stage writeback enable; EX instruction is a load
i_ex_addr, i_ex_data  in  5, DATA_W  EX destination and ALU result
i_mem_we, i_mem_addr, i_mem_data  in  1, 5, DATA_W  MEM-stage forward source
i_wb_we, i_wb_addr, i_wb_data  in  1, 5, DATA_W  regfile write port
o_valid  out  1  ID/EX holds a valid instruction
o_op1, o_op2  out  DATA_W  forwarded rs/rt operands
o_imm  out  DATA_W  sign-extended instr[15:0]
o_wr_addr  out  5  destination register
o_opcode, o_func  out  6,6  instr[31:26], instr[5:0]
o_nextpc  out  DATA_W  redirect target, combinational
o_redirect  out  1  fetch must load o_nextpc, combinational

Behaviour:
- Fields are fixed: rs=[25:21], rt=[20:16], rd=[15:11]. o_wr_addr = rd if opcode==0, else rt.
- Register file: REGS x DATA_W, not reset.
  - Register 0 reads 0.
  - Write on rising edge when i_wb_we & addr!=0 & addr<REGS; other writes are ignored.
  - Reads of addr>=REGS return 0.
  - Same-cycle WB write to a read address returns i_wb_data (write-through).
- Operand select, per operand, priority high to low:
  - addr==0 -> 0
  - EX match (i_ex_we & !i_ex_is_load) -> i_ex_data
  - MEM match -> i_mem_data
  - WB match -> i_wb_data
  - otherwise the regfile read.
- uses_rt = opcode in {0x00, 0x04, 0x05, 0x2B}.
- stall = i_valid & i_ex_we & i_ex_is_load & i_ex_addr!=0 & (i_ex_addr==rs | (uses_rt & i_ex_addr==rt)).
- o_ready = i_ex_ready & !stall & !i_flush.
- Branch/jump resolution uses the forwarded operands:
  - beq (0x04) taken if op1==op2; bne (0x05) taken if op1!=op2.
  - Branch target = i_pc + (sext(imm16)<<2), modulo 2^DATA_W.
  - j (0x02): target {i_pc[DATA_W-1:28], instr[25:0], 2'b00}.
  - jr (opcode 0, func 0x08): target op1.
  - o_redirect = i_valid & o_ready & taken. o_nextpc = target when taken, else i_pc.
- ID/EX register, evaluated each rising edge in this priority:
  1. !i_rst_n -> all registered outputs 0.
  2. i_flush -> o_valid<=0, data fields hold (regardless of i_ex_ready).
  3. !i_ex_ready -> hold everything.
  4. stall | !i_valid -> o_valid<=0 (bubble).
  5. Otherwise load all fields, o_valid<=1.
- Latency: one cycle from accept to o_valid. Throughput is one instruction per cycle absent stalls.
- Reset mid-stall clears o_valid; the held IF/ID instruction is re-presented by fetch.
- Regfile contents survive reset.
- Simultaneous stall and flush: the flush wins, o_ready=0, no redirect.

Test Plan:
- WB writes r5=0x1234 while rs=5 in the same cycle -> o_op1=0x1234 next cycle. A write to r0 -> a later read of r0 returns 0.
- EX non-load r3=0xAA, MEM r3=0xBB, WB r3=0xCC, rs=rt=3 -> o_op1=o_op2=0xAA. Drop EX -> 0xBB.
- EX load to r7, decode "add r8,r7,r1" -> o_ready=0 for 1 cycle and one bubble (o_valid=0). The next cycle forwards from MEM.
- beq r1,r2 with both 0x10, i_pc=0x100, imm=0xFFFE -> o_redirect=1, o_nextpc=0xF8. bne with the same operands -> o_redirect=0.
- jr r31=0x4000 -> o_nextpc=0x4000. With i_ex_ready=0 -> o_redirect=0 and ID/EX held.
- i_flush together with a valid add -> o_valid=0 next cycle, no redirect. Reset with o_valid=1 -> all outputs 0 next edge.
